addr_calc_scheduler: RTL and testbench
======================================

Name: addr_calc_scheduler

Overview:
- Shares one address-calculation channel (base + sample counter) among N_REQ accelerator requesters, e.g. filter in/out and FFT in/out.
- Arbitrates round-robin between the requesters.
- For the granted requester, it captures that requester's filesize and base address, then issues one memory address per unstalled cycle.
- It pulses a per-requester done on completion. It sits between the accelerator wrappers and the data-router memory port.

Parameters:
- N_REQ, 4, number of requesters (2..8)
- ADDR_W, 32, address and filesize width

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, synchronous, active-low
- req  in  N_REQ  per-requester job request, level, held until done
- filesize_bus  in  N_REQ*ADDR_W  per-requester filesize in samples; slice i = bits [i*ADDR_W +: ADDR_W]
- dbl_bus  in  N_REQ  per-requester mode: 1 = two words per sample (FFT out, complex), 0 = one word
- base_bus  in  N_REQ*ADDR_W  per-requester start address, sliced as filesize_bus
- mem_busy  in  1  memory port stall; no address is issued in a cycle where this is high
- gnt  out  N_REQ  one-hot grant, registered
- addr  out  ADDR_W  issued address, registered
- addr_valid  out  1  addr valid this cycle
- count  out  ADDR_W  number of words issued so far in the current job
- done  out  N_REQ  one-cycle completion pulse to the granted requester
- busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (rst_n=0 at a clk edge) forces:
  - state = IDLE; gnt = 0, addr = 0, addr_valid = 0, count = 0, done = 0, busy = 0
  - rr_ptr = 0; total = 0; base_q = 0
  - Reset mid-job aborts the job with no done pulse.
- FSM states: IDLE, LOAD, RUN, DONE.
- IDLE:
  - If any req is high, pick the first requester at or after rr_ptr (searching upward, modulo N_REQ).
  - Register the one-hot gnt; go to LOAD.
  - If no req is high, stay in IDLE.
- LOAD (1 cycle):
  - base_q = base slice of the granted requester.
  - total = filesize, or filesize << 1 when dbl=1; truncate to ADDR_W (result is modulo 2^ADDR_W).
  - count = 0.
  - If total == 0, go to DONE (no addresses issued); otherwise go to RUN.
- RUN, per cycle:
  - mem_busy=1: addr_valid <= 0; count and addr hold.
  - mem_busy=0: addr <= base_q + count (modulo 2^ADDR_W, wraps silently); addr_valid <= 1; count <= count + 1.
  - When the issued word is the last (count == total-1 and mem_busy=0), go to DONE in the next cycle.
- DONE (1 cycle):
  - done[g] = 1 and addr_valid = 0. gnt stays high during DONE and clears on return to IDLE.
  - rr_ptr = g+1 modulo N_REQ.
- Latency:
  - req rising to gnt: 1 cycle.
  - gnt to first addr_valid: 2 cycles (LOAD, then first RUN issue registered), assuming no stall.
  - Addresses are back-to-back when mem_busy stays low.
- Abort: if req[g] falls while in LOAD or RUN:
  - Next state is IDLE; addr_valid <= 0; gnt cleared; no done pulse.
  - rr_ptr = g+1.
- Requester obligations:
  - Drop req within 1 cycle of done. A req still high at IDLE is treated as a new job, but other pending requesters win first via rr_ptr.
  - Hold the filesize, dbl and base slices stable from req assertion through LOAD; they are sampled only in LOAD.
- Simultaneous events:
  - Requests in the same cycle: only one is granted; the others wait.
  - mem_busy during the final word delays DONE until that word issues.
- count is readable at all times; it holds its final value (total) in DONE and is cleared in the next LOAD.

Decomposition:
- Shared package (header, e.g. addr_calc_defs.vh):
  - state encodings (IDLE=2'd0, LOAD=2'd1, RUN=2'd2, DONE=2'd3)
  - default ADDR_W
  - dbl mode constants
- One sub-module, rr_arbiter:
  - inputs: req, rr_ptr
  - output: one-hot grant
  - purely combinational, parameterised by N_REQ
  - reused by the router's bus arbiter.

Test Plan:
1. Basic job. req=4'b0001, filesize=5, dbl=0, base=0x100, mem_busy=0 → gnt=0001 next cycle; addr 0x100..0x104 on 5 consecutive valid cycles; done[0] one cycle after the last address; count=5.
2. Double mode with stall. filesize=3, dbl=1, base=0x200; mem_busy high on the 2nd and 3rd RUN cycles → 6 valid addresses 0x200..0x205, with a 2-cycle gap after 0x200; done[0] after 0x205.
3. Round robin. req=1111 held, each filesize=1 → grant order 0,1,2,3,0, each job ending in a done pulse; no requester granted twice in a row while others are pending.
4. Zero size. filesize=0 → LOAD→DONE; done pulses with no addr_valid; count=0.
5. Abort. req[2] drops after 3 issued addresses (filesize=10) → addr_valid low next cycle, FSM in IDLE, no done[2]; the next grant goes to requester 3 if it is pending.
6. Reset and wrap-around.
   - rst_n=0 mid-RUN → all outputs 0 on the next edge.
   - Separately: base=0xFFFFFFFE, filesize=4 → addresses FFFFFFFE, FFFFFFFF, 0, 1.

Source files
------------

// File: rtl/addr_calc_scheduler_pkg.sv
// Shared definitions for the address-calculation scheduler and its arbiter.
// State encodings, default widths and sample-mode constants.
package addr_calc_scheduler_pkg;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_N_REQ  = 4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    // Words per sample: real data is one word, complex FFT output is two.
    localparam logic DBL_ONE_WORD  = 1'b0;
    localparam logic DBL_TWO_WORDS = 1'b1;

endpackage

// File: rtl/addr_calc_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant to the first request at or
// after i_rr_ptr, searching upward modulo N_REQ.
module rr_arbiter
#(
    parameter int N_REQ = 4,
    parameter int PTR_W = 2
)
(
    input  logic [N_REQ-1:0] i_req,
    input  logic [PTR_W-1:0] i_rr_ptr,
    output logic [N_REQ-1:0] o_gnt
);

    localparam logic [PTR_W:0] NQ = (PTR_W+1)'(N_REQ);

    logic [N_REQ-1:0] w_rot_req;
    logic [N_REQ-1:0] w_rot_gnt;
    logic             w_found;

    // Rotate so the pointer position sits at bit 0, pick lowest set bit, rotate back.
    assign w_rot_req = N_REQ'({i_req, i_req} >> i_rr_ptr);

    always_comb begin
        w_rot_gnt = '0;
        w_found   = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!w_found && w_rot_req[k]) begin
                w_rot_gnt[k] = 1'b1;
                w_found      = 1'b1;
            end
        end
    end

    assign o_gnt = N_REQ'({w_rot_gnt, w_rot_gnt} >> (NQ - {1'b0, i_rr_ptr}));

endmodule

// File: rtl/addr_calc_scheduler.sv
// Shares one base+counter address channel among N_REQ requesters, round-robin.
// The granted job's base/size are captured in LOAD, then one address per unstalled cycle.
module addr_calc_scheduler
    import addr_calc_scheduler_pkg::*;
#(
    parameter int N_REQ  = DEF_N_REQ,
    parameter int ADDR_W = DEF_ADDR_W
)
(
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic [N_REQ-1:0]        i_req,
    input  logic [N_REQ*ADDR_W-1:0] i_filesize_bus,
    input  logic [N_REQ-1:0]        i_dbl_bus,
    input  logic [N_REQ*ADDR_W-1:0] i_base_bus,
    input  logic                    i_mem_busy,
    output logic [N_REQ-1:0]        o_gnt,
    output logic [ADDR_W-1:0]       o_addr,
    output logic                    o_addr_valid,
    output logic [ADDR_W-1:0]       o_count,
    output logic [N_REQ-1:0]        o_done,
    output logic                    o_busy
);

    localparam int PTR_W = $clog2(N_REQ);

    logic [1:0]        r_state;
    logic [N_REQ-1:0]  r_gnt;
    logic [ADDR_W-1:0] r_addr;
    logic              r_valid;
    logic [ADDR_W-1:0] r_count;
    logic [N_REQ-1:0]  r_done;
    logic [PTR_W-1:0]  r_rr_ptr;
    logic [ADDR_W-1:0] r_total;
    logic [ADDR_W-1:0] r_base_q;

    logic [N_REQ-1:0]  w_arb_gnt;
    logic [ADDR_W-1:0] w_fsize;
    logic [ADDR_W-1:0] w_base;
    logic              w_dbl;
    logic [PTR_W-1:0]  w_next_ptr;
    logic [ADDR_W-1:0] w_total;
    logic              w_req_g;
    logic              w_last;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_rr_arbiter (
        .i_req    (i_req),
        .i_rr_ptr (r_rr_ptr),
        .o_gnt    (w_arb_gnt)
    );

    // Select the granted requester's slices and its successor for the rr pointer.
    always_comb begin
        w_fsize    = '0;
        w_base     = '0;
        w_dbl      = DBL_ONE_WORD;
        w_next_ptr = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (r_gnt[i]) begin
                w_fsize    = i_filesize_bus[i*ADDR_W +: ADDR_W];
                w_base     = i_base_bus[i*ADDR_W +: ADDR_W];
                w_dbl      = i_dbl_bus[i];
                w_next_ptr = (i == N_REQ-1) ? '0 : PTR_W'(i+1);
            end
        end
    end

    assign w_total = (w_dbl == DBL_TWO_WORDS) ? (w_fsize << 1) : w_fsize;
    assign w_req_g = |(i_req & r_gnt);
    assign w_last  = (r_count == (r_total - ADDR_W'(1)));

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state  <= ST_IDLE;
            r_gnt    <= '0;
            r_addr   <= '0;
            r_valid  <= 1'b0;
            r_count  <= '0;
            r_done   <= '0;
            r_rr_ptr <= '0;
            r_total  <= '0;
            r_base_q <= '0;
        end else begin
            r_done <= '0;
            case (r_state)
                ST_IDLE: begin
                    r_valid <= 1'b0;
                    if (|i_req) begin
                        r_gnt   <= w_arb_gnt;
                        r_state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (!w_req_g) begin
                        r_gnt    <= '0;
                        r_valid  <= 1'b0;
                        r_rr_ptr <= w_next_ptr;
                        r_state  <= ST_IDLE;
                    end else begin
                        r_base_q <= w_base;
                        r_total  <= w_total;
                        r_count  <= '0;
                        r_state  <= (w_total == '0) ? ST_DONE : ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (!w_req_g) begin
                        r_gnt    <= '0;
                        r_valid  <= 1'b0;
                        r_rr_ptr <= w_next_ptr;
                        r_state  <= ST_IDLE;
                    end else if (i_mem_busy) begin
                        r_valid <= 1'b0;
                    end else begin
                        r_addr  <= r_base_q + r_count;
                        r_valid <= 1'b1;
                        r_count <= r_count + ADDR_W'(1);
                        if (w_last) begin
                            r_state <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    r_done   <= r_gnt;
                    r_gnt    <= '0;
                    r_valid  <= 1'b0;
                    r_rr_ptr <= w_next_ptr;
                    r_state  <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_gnt        = r_gnt;
    assign o_addr       = r_addr;
    assign o_addr_valid = r_valid;
    assign o_count      = r_count;
    assign o_done       = r_done;
    assign o_busy       = (r_state != ST_IDLE);

endmodule

// File: tb/tb_addr_calc_scheduler.sv
// Self-checking bench for addr_calc_scheduler: directed scenarios plus random
// single-requester jobs checked against an address-list reference model.
module tb_addr_calc_scheduler;

    localparam int N = 4;
    localparam int W = 32;

    logic           clk;
    logic           rst_n;
    logic [N-1:0]   req;
    logic [N*W-1:0] filesize_bus;
    logic [N-1:0]   dbl_bus;
    logic [N*W-1:0] base_bus;
    logic           mem_busy;
    logic [N-1:0]   gnt;
    logic [W-1:0]   addr;
    logic           addr_valid;
    logic [W-1:0]   count;
    logic [N-1:0]   done;
    logic           busy;

    int total = 0;
    int bad   = 0;

    addr_calc_scheduler #(.N_REQ(N), .ADDR_W(W)) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_req          (req),
        .i_filesize_bus (filesize_bus),
        .i_dbl_bus      (dbl_bus),
        .i_base_bus     (base_bus),
        .i_mem_busy     (mem_busy),
        .o_gnt          (gnt),
        .o_addr         (addr),
        .o_addr_valid   (addr_valid),
        .o_count        (count),
        .o_done         (done),
        .o_busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Observations from the last drive_job call.
    logic [W-1:0] obs_addr[$];
    int           obs_vcyc[$];
    int           obs_done_cyc;
    int           obs_stall_viol;
    logic [N-1:0] obs_gnt1;
    logic [N-1:0] obs_done_val;
    logic [W-1:0] obs_count_done;

    task automatic apply_reset();
        rst_n    = 1'b0;
        req      = '0;
        mem_busy = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Runs one job for requester g; mem_busy forced on edges st_lo..st_hi, else random.
    task automatic drive_job(input int g, input logic [W-1:0] fs, input logic d,
                             input logic [W-1:0] b, input int stall_pct,
                             input int st_lo, input int st_hi);
        logic prev_busy;
        obs_addr.delete();
        obs_vcyc.delete();
        obs_done_cyc   = -1;
        obs_stall_viol = 0;
        obs_gnt1       = '0;
        obs_done_val   = '0;
        obs_count_done = '0;
        filesize_bus[g*W +: W] = fs;
        base_bus[g*W +: W]     = b;
        dbl_bus[g]             = d;
        req[g]                 = 1'b1;
        mem_busy               = 1'b0;
        prev_busy              = 1'b0;
        for (int c = 1; c <= 400; c++) begin
            @(negedge clk);
            if (c == 1) obs_gnt1 = gnt;
            if (addr_valid) begin
                obs_addr.push_back(addr);
                obs_vcyc.push_back(c);
                if (prev_busy) obs_stall_viol++;
            end
            if (done != '0) begin
                obs_done_val   = done;
                obs_count_done = count;
                obs_done_cyc   = c;
                break;
            end
            mem_busy  = ((c+1 >= st_lo) && (c+1 <= st_hi)) ||
                        (int'($urandom_range(99)) < stall_pct);
            prev_busy = mem_busy;
        end
        req[g]   = 1'b0;
        mem_busy = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req = '0; mem_busy = 1'b0;
        filesize_bus = '0; base_bus = '0; dbl_bus = '0;
        repeat (2) @(negedge clk);
        total++; if (gnt !== '0)        begin bad++; $display("FAIL reset_gnt got=%h want=0", gnt); end
        total++; if (addr !== '0)       begin bad++; $display("FAIL reset_addr got=%h want=0", addr); end
        total++; if (addr_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", addr_valid); end
        total++; if (count !== '0)      begin bad++; $display("FAIL reset_count got=%h want=0", count); end
        total++; if (done !== '0)       begin bad++; $display("FAIL reset_done got=%h want=0", done); end
        total++; if (busy !== 1'b0)     begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        drive_job(0, 32'd5, 1'b0, 32'h100, 0, 0, 0);
        total++; if (obs_gnt1 !== 4'b0001) begin bad++; $display("FAIL basic_gnt_latency got=%b want=0001", obs_gnt1); end
        total++; if (obs_addr.size() != 5) begin bad++; $display("FAIL basic_naddr got=%0d want=5", obs_addr.size()); end
        for (int k = 0; k < obs_addr.size() && k < 5; k++) begin
            total++;
            if (obs_addr[k] !== 32'h100 + k) begin bad++; $display("FAIL basic_addr[%0d] got=%h want=%h", k, obs_addr[k], 32'h100 + k); end
        end
        if (obs_vcyc.size() == 5) begin
            total++; if (obs_vcyc[0] != 3) begin bad++; $display("FAIL basic_first_valid_cycle got=%0d want=3", obs_vcyc[0]); end
            total++; if (obs_vcyc[4] != 7) begin bad++; $display("FAIL basic_back_to_back last_cycle got=%0d want=7", obs_vcyc[4]); end
        end
        total++; if (obs_done_cyc != 8) begin bad++; $display("FAIL basic_done_cycle got=%0d want=8", obs_done_cyc); end
        total++; if (obs_done_val !== 4'b0001) begin bad++; $display("FAIL basic_done got=%b want=0001", obs_done_val); end
        total++; if (obs_count_done !== 32'd5) begin bad++; $display("FAIL basic_count got=%0d want=5", obs_count_done); end
    endtask

    task automatic test_dbl_stall();
        int exp_cyc[6] = '{3, 6, 7, 8, 9, 10};
        drive_job(0, 32'd3, 1'b1, 32'h200, 0, 4, 5);
        total++; if (obs_addr.size() != 6) begin bad++; $display("FAIL dbl_naddr got=%0d want=6", obs_addr.size()); end
        for (int k = 0; k < obs_addr.size() && k < 6; k++) begin
            total++;
            if (obs_addr[k] !== 32'h200 + k || obs_vcyc[k] != exp_cyc[k]) begin
                bad++;
                $display("FAIL dbl_addr[%0d] got=%h@%0d want=%h@%0d", k, obs_addr[k], obs_vcyc[k], 32'h200 + k, exp_cyc[k]);
            end
        end
        total++; if (obs_done_cyc != 11) begin bad++; $display("FAIL dbl_done_cycle got=%0d want=11", obs_done_cyc); end
        total++; if (obs_count_done !== 32'd6) begin bad++; $display("FAIL dbl_count got=%0d want=6", obs_count_done); end
        total++; if (obs_stall_viol != 0) begin bad++; $display("FAIL dbl_issue_while_stalled got=%0d want=0", obs_stall_viol); end
    endtask

    task automatic test_round_robin();
        int p;
        int got_addr;
        logic [W-1:0] a_seen;
        logic [N-1:0] d_seen;
        apply_reset();
        for (int i = 0; i < N; i++) begin
            filesize_bus[i*W +: W] = 32'd1;
            base_bus[i*W +: W]     = 32'h1000 * (i + 1);
        end
        dbl_bus = '0;
        req = 4'b1111;
        p = 0;
        for (int j = 0; j < 5; j++) begin
            got_addr = 0;
            a_seen   = '0;
            d_seen   = '0;
            for (int c = 0; c < 20; c++) begin
                @(negedge clk);
                if (addr_valid) begin got_addr++; a_seen = addr; end
                if (done != '0) begin d_seen = done; break; end
            end
            total++; if (d_seen !== (4'b0001 << p)) begin bad++; $display("FAIL rr_done[%0d] got=%b want=%b", j, d_seen, 4'b0001 << p); end
            total++; if (got_addr != 1 || a_seen !== 32'h1000 * (p + 1)) begin
                bad++; $display("FAIL rr_addr[%0d] got=%h n=%0d want=%h n=1", j, a_seen, got_addr, 32'h1000 * (p + 1));
            end
            p = (p + 1) % N;
        end
        req = '0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_zero();
        drive_job(1, 32'd0, 1'b0, 32'h300, 0, 0, 0);
        total++; if (obs_addr.size() != 0) begin bad++; $display("FAIL zero_naddr got=%0d want=0", obs_addr.size()); end
        total++; if (obs_done_cyc != 3) begin bad++; $display("FAIL zero_done_cycle got=%0d want=3", obs_done_cyc); end
        total++; if (obs_done_val !== 4'b0010) begin bad++; $display("FAIL zero_done got=%b want=0010", obs_done_val); end
        total++; if (obs_count_done !== 32'd0) begin bad++; $display("FAIL zero_count got=%0d want=0", obs_count_done); end
        // Doubling 2^31 samples wraps the word total to zero.
        drive_job(2, 32'h8000_0000, 1'b1, 32'h400, 0, 0, 0);
        total++; if (obs_addr.size() != 0 || obs_done_val !== 4'b0100) begin
            bad++; $display("FAIL zero_dbl_wrap got n=%0d done=%b want n=0 done=0100", obs_addr.size(), obs_done_val);
        end
    endtask

    task automatic test_abort();
        int nv;
        bit done2_seen;
        logic [N-1:0] d_seen;
        apply_reset();
        dbl_bus = '0;
        filesize_bus[2*W +: W] = 32'd10; base_bus[2*W +: W] = 32'h500;
        filesize_bus[3*W +: W] = 32'd2;  base_bus[3*W +: W] = 32'h600;
        req = 4'b1100;
        nv = 0;
        done2_seen = 0;
        for (int c = 0; c < 40 && nv < 3; c++) begin
            @(negedge clk);
            if (addr_valid) nv++;
            if (done[2]) done2_seen = 1;
        end
        total++; if (nv != 3) begin bad++; $display("FAIL abort_reach3 got=%0d want=3", nv); end
        req[2] = 1'b0;
        @(negedge clk);
        total++; if (addr_valid !== 1'b0 || busy !== 1'b0 || gnt !== '0 || done !== '0) begin
            bad++; $display("FAIL abort_idle got valid=%b busy=%b gnt=%b done=%b want 0/0/0000/0000", addr_valid, busy, gnt, done);
        end
        @(negedge clk);
        total++; if (gnt !== 4'b1000) begin bad++; $display("FAIL abort_next_gnt got=%b want=1000", gnt); end
        d_seen = '0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done[2]) done2_seen = 1;
            if (done != '0) begin d_seen = done; break; end
        end
        req = '0;
        total++; if (d_seen !== 4'b1000) begin bad++; $display("FAIL abort_done3 got=%b want=1000", d_seen); end
        total++; if (done2_seen) begin bad++; $display("FAIL abort_no_done2 got=1 want=0"); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_run();
        int nv;
        apply_reset();
        drive_job(1, 32'd2, 1'b0, 32'h700, 0, 0, 0);
        filesize_bus[1*W +: W] = 32'd8;
        req[1] = 1'b1;
        nv = 0;
        for (int c = 0; c < 40 && nv < 2; c++) begin
            @(negedge clk);
            if (addr_valid) nv++;
        end
        rst_n = 1'b0;
        req   = '0;
        @(negedge clk);
        total++; if (gnt !== '0 || addr !== '0 || addr_valid !== 1'b0 || count !== '0 || done !== '0 || busy !== 1'b0) begin
            bad++; $display("FAIL midrun_reset got gnt=%b addr=%h v=%b cnt=%h done=%b busy=%b want all 0",
                            gnt, addr, addr_valid, count, done, busy);
        end
        rst_n = 1'b1;
        filesize_bus[0*W +: W] = 32'd1;
        filesize_bus[3*W +: W] = 32'd1;
        req = 4'b1001;
        @(negedge clk);
        total++; if (gnt !== 4'b0001) begin bad++; $display("FAIL midrun_ptr_cleared got=%b want=0001", gnt); end
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (done != '0) break;
        end
        req = '0;
        @(negedge clk);
    endtask

    task automatic test_wrap();
        logic [W-1:0] exp_a[4] = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0, 32'h1};
        drive_job(3, 32'd4, 1'b0, 32'hFFFF_FFFE, 0, 0, 0);
        total++; if (obs_addr.size() != 4) begin bad++; $display("FAIL wrap_naddr got=%0d want=4", obs_addr.size()); end
        for (int k = 0; k < obs_addr.size() && k < 4; k++) begin
            total++;
            if (obs_addr[k] !== exp_a[k]) begin bad++; $display("FAIL wrap_addr[%0d] got=%h want=%h", k, obs_addr[k], exp_a[k]); end
        end
    endtask

    task automatic test_random();
        int g;
        logic [W-1:0] fs, b, tot;
        logic d;
        int errs;
        for (int j = 0; j < 24; j++) begin
            g   = int'($urandom_range(N-1));
            fs  = W'($urandom_range(12));
            d   = 1'($urandom_range(1));
            b   = $urandom;
            tot = d ? (fs << 1) : fs;
            drive_job(g, fs, d, b, 30, 0, 0);
            errs = 0;
            if (obs_addr.size() != int'(tot)) errs++;
            for (int k = 0; k < obs_addr.size(); k++)
                if (obs_addr[k] !== b + W'(k)) errs++;
            total++; if (errs != 0) begin
                bad++; $display("FAIL rand_addrs[%0d] g=%0d fs=%0d dbl=%b base=%h got n=%0d errs=%0d want n=%0d",
                                j, g, fs, d, b, obs_addr.size(), errs, tot);
            end
            total++; if (obs_done_val !== (4'b0001 << g) || obs_count_done !== tot) begin
                bad++; $display("FAIL rand_done[%0d] got done=%b cnt=%0d want done=%b cnt=%0d",
                                j, obs_done_val, obs_count_done, 4'b0001 << g, tot);
            end
            total++; if (obs_stall_viol != 0) begin bad++; $display("FAIL rand_stall[%0d] got=%0d want=0", j, obs_stall_viol); end
        end
    endtask

    initial begin
        rst_n = 1'b0; req = '0; mem_busy = 1'b0;
        filesize_bus = '0; base_bus = '0; dbl_bus = '0;
        test_reset();
        test_basic();
        test_dbl_stall();
        test_round_robin();
        test_zero();
        test_abort();
        test_reset_mid_run();
        test_wrap();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
